// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter and its update rule.
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
      if (taken) begin
         return (ctr == ST) ? ST : ctr_t'(ctr + 2'd1);
      end
      return (ctr == SNT) ? SNT : ctr_t'(ctr - 2'd1);
   endfunction

endpackage

// File: rtl/bp_table.sv
// BTB storage: valid/counter flops with async reset, tag/target/jump payload without reset.
// Two async read ports (fetch lookup and E-stage read-modify-write) and one write port.
module bp_table
   import bp_pkg::*;
#(
   parameter int ENTRIES   = 16,
   parameter int IDX_BITS  = $clog2(ENTRIES),
   parameter int PAYLOAD_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IDX_BITS-1:0]  lookupIdx,
   output logic                 lookupValid,
   output ctr_t                 lookupCtr,
   output logic [PAYLOAD_W-1:0] lookupPayload,
   input  logic [IDX_BITS-1:0]  updIdx,
   output logic                 updValid,
   output ctr_t                 updCtr,
   output logic [PAYLOAD_W-1:0] updPayload,
   input  logic                 wrEn,
   input  logic [IDX_BITS-1:0]  wrIdx,
   input  ctr_t                 wrCtr,
   input  logic [PAYLOAD_W-1:0] wrPayload
);

   logic [ENTRIES-1:0]   validArr;
   ctr_t                 ctrArr     [ENTRIES];
   logic [PAYLOAD_W-1:0] payloadArr [ENTRIES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         validArr <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctrArr[i] <= WNT;
         end
      end else if (wrEn) begin
         validArr[wrIdx] <= 1'b1;
         ctrArr[wrIdx]   <= wrCtr;
      end
   end

   // Tags and targets are qualified by valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         payloadArr[wrIdx] <= wrPayload;
      end
   end

   assign lookupValid   = validArr[lookupIdx];
   assign lookupCtr     = ctrArr[lookupIdx];
   assign lookupPayload = payloadArr[lookupIdx];
   assign updValid      = validArr[updIdx];
   assign updCtr        = ctrArr[updIdx];
   assign updPayload    = payloadArr[updIdx];

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor: zero-latency fetch lookup, E-stage training and mispredict detection.
// Optional gshare indexing with a non-speculative global history is enabled by defining BP_GSHARE_EN.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ENTRIES    = 16,
   parameter int IDX_BITS   = $clog2(ENTRIES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] PCF,
   output logic                  PredTakenF,
   output logic [DATA_WIDTH-1:0] PredTargetF,
   output logic [IDX_BITS-1:0]   GhrF,
   input  logic                  InstrValidE,
   input  logic                  BranchE,
   input  logic                  JumpE,
   input  logic                  TakenE,
   input  logic [DATA_WIDTH-1:0] TargetE,
   input  logic [DATA_WIDTH-1:0] PCE,
   input  logic                  PredTakenE,
   input  logic [DATA_WIDTH-1:0] PredTargetE,
   input  logic [IDX_BITS-1:0]   GhrE,
   output logic                  MispredictE,
   output logic [DATA_WIDTH-1:0] RecoverPCE
);

   localparam int TAG_W     = DATA_WIDTH - IDX_BITS - 2;
   localparam int PAYLOAD_W = TAG_W + DATA_WIDTH + 1;

   typedef struct packed {
      logic                  valid;
      logic [TAG_W-1:0]      tag;
      logic [DATA_WIDTH-1:0] target;
      logic                  jump;
      ctr_t                  ctr;
   } btb_entry_t;

   logic [IDX_BITS-1:0]  pcIdxF, pcIdxE, lookupIdx, updIdx;
   logic [TAG_W-1:0]     tagF, tagE;
   logic                 lookupValid, updValid;
   ctr_t                 lookupCtr, updCtr, wrCtr;
   logic [PAYLOAD_W-1:0] lookupPayload, updPayload, wrPayload;
   logic                 wrEn, updE, hitF, hitE;
   btb_entry_t           lookupEnt, updEnt;
   logic                 unusedBits;

   assign pcIdxF     = PCF[IDX_BITS+1:2];
   assign pcIdxE     = PCE[IDX_BITS+1:2];
   assign tagF       = PCF[DATA_WIDTH-1:IDX_BITS+2];
   assign tagE       = PCE[DATA_WIDTH-1:IDX_BITS+2];
   assign unusedBits = ^{PCF[1:0], PCE[1:0]};

   assign updE = InstrValidE && (BranchE || JumpE);

`ifdef BP_GSHARE_EN
   logic [IDX_BITS-1:0] ghr;

   // Shift a resolved outcome into the LSB; works down to a 1-bit history.
   function automatic logic [IDX_BITS-1:0] histShift(input logic [IDX_BITS-1:0] hist,
                                                     input logic taken);
      logic [IDX_BITS:0] ext;
      ext = {hist, taken};
      return ext[IDX_BITS-1:0];
   endfunction

   // A mispredicting branch rebuilds history from the snapshot it was predicted with.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr <= '0;
      end else if (updE && BranchE) begin
         ghr <= MispredictE ? histShift(GhrE, TakenE) : histShift(ghr, TakenE);
      end
   end

   assign lookupIdx = pcIdxF ^ ghr;
   assign updIdx    = pcIdxE ^ GhrE;
   assign GhrF      = ghr;
`else
   logic unusedGhr;

   assign unusedGhr = ^GhrE;
   assign lookupIdx = pcIdxF;
   assign updIdx    = pcIdxE;
   assign GhrF      = '0;
`endif

   bp_table #(
      .ENTRIES  (ENTRIES),
      .IDX_BITS (IDX_BITS),
      .PAYLOAD_W(PAYLOAD_W)
   ) uTable (
      .clk          (clk),
      .rst          (rst),
      .lookupIdx    (lookupIdx),
      .lookupValid  (lookupValid),
      .lookupCtr    (lookupCtr),
      .lookupPayload(lookupPayload),
      .updIdx       (updIdx),
      .updValid     (updValid),
      .updCtr       (updCtr),
      .updPayload   (updPayload),
      .wrEn         (wrEn),
      .wrIdx        (updIdx),
      .wrCtr        (wrCtr),
      .wrPayload    (wrPayload)
   );

   assign lookupEnt = {lookupValid, lookupPayload, lookupCtr};
   assign updEnt    = {updValid, updPayload, updCtr};

   assign hitF        = lookupEnt.valid && (lookupEnt.tag == tagF);
   assign hitE        = updEnt.valid && (updEnt.tag == tagE);
   assign PredTakenF  = hitF && (lookupEnt.jump || lookupEnt.ctr[1]);
   assign PredTargetF = lookupEnt.target;

   // Hits train in place; a taken miss allocates weakly-taken; a not-taken miss leaves the table alone.
   always_comb begin
      wrEn      = 1'b0;
      wrCtr     = WT;
      wrPayload = {tagE, TargetE, JumpE};
      if (updE) begin
         if (hitE) begin
            wrEn      = 1'b1;
            wrCtr     = ctr_next(updEnt.ctr, TakenE);
            wrPayload = {tagE, (TakenE ? TargetE : updEnt.target), JumpE};
         end else if (TakenE) begin
            wrEn = 1'b1;
         end
      end
   end

   assign MispredictE = (updE && ((PredTakenE != TakenE) ||
                                  (TakenE && (PredTargetE != TargetE)))) ||
                        (InstrValidE && !BranchE && !JumpE && PredTakenE);

   assign RecoverPCE = (updE && TakenE) ? TargetE : PCE + DATA_WIDTH'(4);

endmodule
